// File: rtl/keypad_emulator_pkg.sv
// keypad_emulator_pkg
// Shared types and helpers for the 4x4 keypad emulator.
//   state_t   : emulator FSM states (IDLE / PRESS / RELEASE)
//   KEY_W     : width of a key code (row = [3:2], col = [1:0])
//   ROWS/COLS : matrix dimensions
//   key_row() / key_col() : split a key code into its matrix coordinates
package keypad_emulator_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/keypad_emulator_fifo.sv
// keypad_emulator_fifo
// Synchronous FIFO of key codes (DEPTH x KEY_W). DEPTH must be a power of
// two so the pointers wrap naturally.
// Ports:
//   CLOCK_50 : clock
//   reset_n  : asynchronous active-low reset (empties the queue)
//   wr_en    : write request (ignored while full, even with a same-cycle read)
//   wr_data  : key code to enqueue
//   rd_en    : read request (ignored while empty)
//   rd_data  : head of the queue (valid while !empty)
//   full     : queue holds DEPTH entries
//   empty    : queue holds no entries
//   level    : current occupancy, 0..DEPTH
module keypad_emulator_fifo
  import keypad_emulator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [KEY_W-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [KEY_W-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator
// Emulates the 4x4 matrix keypad seen by the keypad scanner. Key codes are
// queued via valid/ready; each key is held for PRESS_TICKS ticks, then
// released for RELEASE_TICKS ticks. While held, the key's column is pulled
// low whenever the scanner grounds the key's row.
// Optional build macro: KEYPAD_EMULATOR_BOUNCE_EN -- the first BOUNCE_TICKS
// ticks of every press toggle on/off each tick before settling.
// Ports:
//   CLOCK_50   : system clock
//   reset_n    : asynchronous active-low reset
//   key_valid  : key_code is offered
//   key_code   : key to type (row = [3:2], col = [1:0])
//   key_ready  : queue can accept a key
//   row_n      : scanner rows, active low (1 when released / tri-stated)
//   col_drive  : 1 = pull that column low (top level maps 0 to high-Z)
//   busy       : a key is pressed/released or the queue is non-empty
//   fifo_level : current queue occupancy
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int CLK_DIV       = 50000,
  parameter int PRESS_TICKS   = 40,
  parameter int RELEASE_TICKS = 40,
  parameter int FIFO_DEPTH    = 8,
  parameter int BOUNCE_TICKS  = 6
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        key_valid,
  input  logic [KEY_W-1:0]            key_code,
  output logic                        key_ready,
  input  logic [ROWS-1:0]             row_n,
  output logic [COLS-1:0]             col_drive,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  // A bounce window longer than the press is cut short so the press
  // always ends in its steady phase.
  localparam int BOUNCE_EFF = (BOUNCE_TICKS >= PRESS_TICKS) ? PRESS_TICKS - 1 : BOUNCE_TICKS;
  localparam int MAXT_PR    = (PRESS_TICKS > RELEASE_TICKS) ? PRESS_TICKS : RELEASE_TICKS;
  localparam int MAXT       = (MAXT_PR > BOUNCE_EFF) ? MAXT_PR : BOUNCE_EFF;
  localparam int TW         = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    pre_cnt;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [KEY_W-1:0] cur_key;
  logic [ROWS-1:0]  row_s1;
  logic [ROWS-1:0]  row_s2;
  logic [COLS-1:0]  drive_next;
  logic             press_en;
  logic             fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] fifo_head;

  keypad_emulator_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .wr_en    (key_valid),
    .wr_data  (key_code),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign key_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign tick      = (pre_cnt == PW'(CLK_DIV - 1));

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  // Even tick indices inside the bounce window are "on", odd ones "off".
  assign press_en = (tick_cnt >= TW'(BOUNCE_EFF)) || !tick_cnt[0];
`else
  assign press_en = 1'b1;
`endif

  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    drive_next = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = PRESS;
        end
      end
      PRESS: begin
        if (press_en && !row_s2[key_row(cur_key)])
          drive_next[key_col(cur_key)] = 1'b1;
        if (tick && (tick_cnt == TW'(PRESS_TICKS - 1)))
          state_next = RELEASE;
      end
      RELEASE: begin
        if (tick && (tick_cnt == TW'(RELEASE_TICKS - 1)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      tick_cnt  <= '0;
      cur_key   <= '0;
      row_s1    <= '1;
      row_s2    <= '1;
      col_drive <= '0;
    end else begin
      state     <= state_next;
      row_s1    <= row_n;
      row_s2    <= row_s1;
      col_drive <= drive_next;
      if (fifo_rd) cur_key <= fifo_head;
      // Restarting the prescaler on every state change makes each phase an
      // exact multiple of CLK_DIV cycles.
      if ((state_next != state) || (state == IDLE)) begin
        pre_cnt  <= '0;
        tick_cnt <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
// Self-checking bench for keypad_emulator with a small timeline model:
// the model tracks the queue, the phase (idle/press/release) and elapsed
// cycles in the phase, and predicts col_drive from the phase one cycle back
// and row_n three cycles back.
module tb_keypad_emulator;

  localparam int CLK_DIV       = 4;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int PRESS_TICKS   = 5;
`else
  localparam int PRESS_TICKS   = 3;
`endif
  localparam int RELEASE_TICKS = 2;
  localparam int FIFO_DEPTH    = 4;
  localparam int BOUNCE_TICKS  = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] row_n;
  logic [3:0] col_drive;
  logic       busy;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  // model state: 0 idle, 1 press, 2 release
  logic [3:0] q[$];
  int         m_st;
  int         m_el;
  logic [3:0] m_key;
  logic [3:0] rn_h[3];

  keypad_emulator #(
    .CLK_DIV       (CLK_DIV),
    .PRESS_TICKS   (PRESS_TICKS),
    .RELEASE_TICKS (RELEASE_TICKS),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .BOUNCE_TICKS  (BOUNCE_TICKS)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .row_n      (row_n),
    .col_drive  (col_drive),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic bit m_en(int e);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    int t = e / CLK_DIV;
    int b = (BOUNCE_TICKS >= PRESS_TICKS) ? PRESS_TICKS - 1 : BOUNCE_TICKS;
    return (t >= b) || (t % 2 == 0);
`else
    return (e >= 0);
`endif
  endfunction

  task automatic check(string tag, string what, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s %s: observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_st  = 0;
    m_el  = 0;
    m_key = '0;
    foreach (rn_h[i]) rn_h[i] = '1;
  endtask

  // One clock: predict, advance the model, clock the DUT, compare.
  task automatic step(string tag);
    logic [3:0] exp_col;
    bit         do_push;
    logic [3:0] rr;
    exp_col = '0;
    rn_h[2] = rn_h[1];
    rn_h[1] = rn_h[0];
    rn_h[0] = row_n;
    rr = rn_h[2];
    if (m_st == 1 && m_en(m_el) && rr[m_key[3:2]] == 1'b0)
      exp_col[m_key[1:0]] = 1'b1;
    do_push = key_valid && (q.size() < FIFO_DEPTH);
    case (m_st)
      0: if (q.size() > 0) begin
        m_key = q.pop_front();
        m_st  = 1;
        m_el  = 0;
      end
      1: begin
        m_el++;
        if (m_el == PRESS_TICKS * CLK_DIV) begin m_st = 2; m_el = 0; end
      end
      default: begin
        m_el++;
        if (m_el == RELEASE_TICKS * CLK_DIV) begin m_st = 0; m_el = 0; end
      end
    endcase
    if (do_push) q.push_back(key_code);
    @(posedge CLOCK_50);
    #1;
    check(tag, "col_drive", {4'b0, col_drive}, {4'b0, exp_col});
    check(tag, "fifo_level", {5'b0, fifo_level}, 8'(q.size()));
    check(tag, "key_ready", {7'b0, key_ready}, {7'b0, (q.size() < FIFO_DEPTH)});
    check(tag, "busy", {7'b0, busy}, {7'b0, (m_st != 0 || q.size() != 0)});
  endtask

  task automatic push(string tag, logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step(tag);
    key_valid = 1'b0;
  endtask

  task automatic run_idle(string tag, int budget);
    int n = 0;
    while ((m_st != 0 || q.size() != 0) && n < budget) begin
      step(tag);
      n++;
    end
    total++;
    assert (n < budget)
    else begin
      bad++;
      $error("FAIL %s timeout: observed=%0d cycles expected<%0d", tag, n, budget);
    end
    repeat (2) step(tag);
  endtask

  initial begin
    logic [3:0] pat[4];
    logic [3:0] codes[6];
    int         n;

    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    codes[0] = 4'd1; codes[1] = 4'd6; codes[2] = 4'd11;
    codes[3] = 4'd12; codes[4] = 4'd3; codes[5] = 4'd14;

    // reset state
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_code  = '0;
    row_n     = '1;
    model_reset();
    #1;
    check("reset", "col_drive", {4'b0, col_drive}, 8'h00);
    check("reset", "fifo_level", {5'b0, fifo_level}, 8'h00);
    check("reset", "key_ready", {7'b0, key_ready}, 8'h01);
    check("reset", "busy", {7'b0, busy}, 8'h00);
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    step("post_reset");

    // single key, its row held low
    row_n = 4'b1101;
    push("key5", 4'd5);
    run_idle("key5", 200);

    // row walk while key 13 is held
    row_n = 4'b1111;
    push("key13", 4'd13);
    n = 0;
    while ((m_st != 0 || q.size() != 0) && n < 200) begin
      row_n = pat[(n / 3) % 4];
      step("key13");
      n++;
    end
    row_n = 4'b1111;
    run_idle("key13", 50);

    // six back-to-back pushes; queue saturates at FIFO_DEPTH
    row_n = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1;
      key_code  = codes[i];
      step("burst");
      check("burst", "level_max", {7'b0, (fifo_level <= 3'd4)}, 8'h01);
    end
    key_valid = 1'b0;
    n = 0;
    while ((m_st != 0 || q.size() != 0) && n < 400) begin
      row_n = 4'($urandom);
      step("burst_drain");
      n++;
    end
    row_n = 4'b1111;
    run_idle("burst_drain", 50);

    // reset in the middle of a press, with another key still queued
    row_n = 4'b1110;
    push("rst_mid", 4'd0);
    push("rst_mid", 4'd7);
    n = 0;
    while (!(m_st == 1 && m_el == 6) && n < 50) begin
      step("rst_mid");
      n++;
    end
    check("rst_mid", "pressing", {4'b0, col_drive}, 8'h01);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid", "async_col", {4'b0, col_drive}, 8'h00);
    check("rst_mid", "async_level", {5'b0, fifo_level}, 8'h00);
    check("rst_mid", "async_ready", {7'b0, key_ready}, 8'h01);
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    row_n = 4'b0000;
    repeat (40) step("rst_after");

    // all rows low: only the key's own column may drive
    row_n = 4'b0000;
    push("key10", 4'd10);
    run_idle("key10", 200);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      key_valid = ($urandom_range(0, 5) == 0);
      key_code  = 4'($urandom);
      row_n     = 4'($urandom);
      step("random");
    end
    key_valid = 1'b0;
    run_idle("random_drain", 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
